// File: rtl/axi_tmr_voter_reg.sv
// Registered TMR majority voter with per-replica saturating error counters and
// TRIPLEX -> DUPLEX -> SIMPLEX degradation. Optional fault injection: TMR_VOTER_ERR_INJ_EN.
module axi_tmr_voter_reg #(
   parameter int WIDTH        = 8,
   parameter int CNT_W        = 4,
   parameter int FAULT_THRESH = 3
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic             clr,
`ifdef TMR_VOTER_ERR_INJ_EN
   input  logic             inj_en,
   input  logic [1:0]       inj_sel,
   input  logic [WIDTH-1:0] inj_mask,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] d_out,
   output logic             err_flag,
   output logic [2:0]       err_d,
   output logic             uncorr,
   output logic [1:0]       mode,
   output logic [2:0]       fail_mask,
   output logic [CNT_W-1:0] err_cnt0,
   output logic [CNT_W-1:0] err_cnt1,
   output logic [CNT_W-1:0] err_cnt2
);

   localparam logic [1:0]       MODE_TRIPLEX = 2'b00;
   localparam logic [1:0]       MODE_DUPLEX  = 2'b01;
   localparam logic [1:0]       MODE_SIMPLEX = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   function automatic logic [1:0] mode_of(input logic [2:0] m);
      case (m)
         3'b000:                 return MODE_TRIPLEX;
         3'b001, 3'b010, 3'b100: return MODE_DUPLEX;
         default:                return MODE_SIMPLEX;
      endcase
   endfunction

   logic [2:0][WIDTH-1:0] w_rep_p0;
   logic [WIDTH-1:0]      w_maj_p0;
   logic [WIDTH-1:0]      w_vote_p0;
   logic [WIDTH-1:0]      w_dup_a_p0;
   logic [WIDTH-1:0]      w_dup_b_p0;
   logic [WIDTH-1:0]      w_solo_p0;
   logic [2:0]            w_err_d_p0;
   logic                  w_uncorr_p0;
   logic [2:0][CNT_W-1:0] w_cnt_nxt_p0;
   logic [2:0]            w_cross_p0;
   logic [2:0]            w_mask_nxt_p0;

   logic                  r_out_valid_p1;
   logic [WIDTH-1:0]      r_d_out_p1;
   logic                  r_err_flag_p1;
   logic [2:0]            r_err_d_p1;
   logic                  r_uncorr_p1;
   logic [1:0]            r_mode;
   logic [2:0]            r_fail_mask;
   logic [2:0][CNT_W-1:0] r_cnt;

`ifdef TMR_VOTER_ERR_INJ_EN
   always_comb begin
      w_rep_p0 = {d2, d1, d0};
      if (inj_en) begin
         case (inj_sel)
            2'd0:    w_rep_p0[0] = d0 ^ inj_mask;
            2'd1:    w_rep_p0[1] = d1 ^ inj_mask;
            2'd2:    w_rep_p0[2] = d2 ^ inj_mask;
            default: w_rep_p0    = {d2, d1, d0};
         endcase
      end
   end
`else
   assign w_rep_p0 = {d2, d1, d0};
`endif

   // Stage p0: survivor selection and vote under the current mode
   always_comb begin
      w_maj_p0 = (w_rep_p0[0] & w_rep_p0[1]) | (w_rep_p0[1] & w_rep_p0[2]) |
                 (w_rep_p0[0] & w_rep_p0[2]);
      w_dup_a_p0 = w_rep_p0[0];
      w_dup_b_p0 = w_rep_p0[1];
      if (r_fail_mask[0]) begin
         w_dup_a_p0 = w_rep_p0[1];
         w_dup_b_p0 = w_rep_p0[2];
      end else if (r_fail_mask[1]) begin
         w_dup_b_p0 = w_rep_p0[2];
      end
      if (!r_fail_mask[0])      w_solo_p0 = w_rep_p0[0];
      else if (!r_fail_mask[1]) w_solo_p0 = w_rep_p0[1];
      else                      w_solo_p0 = w_rep_p0[2];

      w_vote_p0   = w_maj_p0;
      w_err_d_p0  = '0;
      w_uncorr_p0 = 1'b0;
      case (r_mode)
         MODE_TRIPLEX: begin
            for (int r = 0; r < 3; r++) w_err_d_p0[r] = (w_rep_p0[r] != w_maj_p0);
         end
         MODE_DUPLEX: begin
            w_vote_p0   = w_dup_a_p0;
            w_uncorr_p0 = (w_dup_a_p0 != w_dup_b_p0);
         end
         default: w_vote_p0 = w_solo_p0;
      endcase
   end

   // Stage p0: counter increment and threshold crossing
   always_comb begin
      w_cnt_nxt_p0 = r_cnt;
      w_cross_p0   = '0;
      for (int r = 0; r < 3; r++) begin
         if (w_err_d_p0[r] && !r_fail_mask[r]) w_cnt_nxt_p0[r] = sat_inc(r_cnt[r]);
         w_cross_p0[r] = (FAULT_THRESH != 0) && w_err_d_p0[r] &&
                         (int'(w_cnt_nxt_p0[r]) >= FAULT_THRESH);
      end
      w_mask_nxt_p0 = r_fail_mask | w_cross_p0;
      // All three crossing at once would leave no survivor; replica 0 is kept.
      if (w_mask_nxt_p0 == 3'b111) w_mask_nxt_p0 = 3'b110;
   end

   // Stage p1: registered outputs and voter state
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_out_valid_p1 <= 1'b0;
         r_d_out_p1     <= '0;
         r_err_flag_p1  <= 1'b0;
         r_err_d_p1     <= '0;
         r_uncorr_p1    <= 1'b0;
         r_mode         <= MODE_TRIPLEX;
         r_fail_mask    <= '0;
         r_cnt          <= '0;
      end else begin
         r_out_valid_p1 <= in_valid;
         r_err_flag_p1  <= in_valid & (|w_err_d_p0);
         r_err_d_p1     <= in_valid ? w_err_d_p0 : 3'b000;
         r_uncorr_p1    <= in_valid & w_uncorr_p0;
         if (in_valid) r_d_out_p1 <= w_vote_p0;
         if (clr) begin
            r_cnt       <= '0;
            r_fail_mask <= '0;
            r_mode      <= MODE_TRIPLEX;
         end else if (in_valid) begin
            r_cnt       <= w_cnt_nxt_p0;
            r_fail_mask <= w_mask_nxt_p0;
            r_mode      <= mode_of(w_mask_nxt_p0);
         end
      end
   end

   assign out_valid = r_out_valid_p1;
   assign d_out     = r_d_out_p1;
   assign err_flag  = r_err_flag_p1;
   assign err_d     = r_err_d_p1;
   assign uncorr    = r_uncorr_p1;
   assign mode      = r_mode;
   assign fail_mask = r_fail_mask;
   assign err_cnt0  = r_cnt[0];
   assign err_cnt1  = r_cnt[1];
   assign err_cnt2  = r_cnt[2];

endmodule

// File: tb/tb_axi_tmr_voter_reg.sv
// Scoreboard bench for axi_tmr_voter_reg: two instances (FAULT_THRESH 3 and 0) share
// directed and random stimulus; a behavioural model predicts each output beat.
module tb_axi_tmr_voter_reg;
   localparam int W    = 8;
   localparam int CW   = 4;
   localparam int TH_A = 3;
   localparam int TH_B = 0;

   typedef struct packed {
      logic          ov;
      logic [W-1:0]  dout;
      logic          ef;
      logic [2:0]    ed;
      logic          uc;
      logic [1:0]    mode;
      logic [2:0]    fm;
      logic [CW-1:0] c0;
      logic [CW-1:0] c1;
      logic [CW-1:0] c2;
   } obs_t;

   logic         aclk = 1'b0;
   logic         areset = 1'b1;
   logic         in_valid = 1'b0;
   logic         clr = 1'b0;
   logic [W-1:0] d0 = '0, d1 = '0, d2 = '0;
`ifdef TMR_VOTER_ERR_INJ_EN
   logic         inj_en = 1'b0;
   logic [1:0]   inj_sel = 2'd0;
   logic [W-1:0] inj_mask = '0;
`endif

   logic a_ov, a_ef, a_uc, b_ov, b_ef, b_uc;
   logic [W-1:0] a_dout, b_dout;
   logic [2:0] a_ed, a_fm, b_ed, b_fm;
   logic [1:0] a_mode, b_mode;
   logic [CW-1:0] a_c0, a_c1, a_c2, b_c0, b_c1, b_c2;
   obs_t obs_a, obs_b;

   assign obs_a = {a_ov, a_dout, a_ef, a_ed, a_uc, a_mode, a_fm, a_c0, a_c1, a_c2};
   assign obs_b = {b_ov, b_dout, b_ef, b_ed, b_uc, b_mode, b_fm, b_c0, b_c1, b_c2};

   always #5 aclk = ~aclk;

   axi_tmr_voter_reg #(.WIDTH(W), .CNT_W(CW), .FAULT_THRESH(TH_A)) u_dut (
      .aclk(aclk), .areset(areset), .in_valid(in_valid),
      .d0(d0), .d1(d1), .d2(d2), .clr(clr),
`ifdef TMR_VOTER_ERR_INJ_EN
      .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
`endif
      .out_valid(a_ov), .d_out(a_dout), .err_flag(a_ef), .err_d(a_ed), .uncorr(a_uc),
      .mode(a_mode), .fail_mask(a_fm), .err_cnt0(a_c0), .err_cnt1(a_c1), .err_cnt2(a_c2)
   );

   axi_tmr_voter_reg #(.WIDTH(W), .CNT_W(CW), .FAULT_THRESH(TH_B)) u_sat (
      .aclk(aclk), .areset(areset), .in_valid(in_valid),
      .d0(d0), .d1(d1), .d2(d2), .clr(clr),
`ifdef TMR_VOTER_ERR_INJ_EN
      .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
`endif
      .out_valid(b_ov), .d_out(b_dout), .err_flag(b_ef), .err_d(b_ed), .uncorr(b_uc),
      .mode(b_mode), .fail_mask(b_fm), .err_cnt0(b_c0), .err_cnt1(b_c1), .err_cnt2(b_c2)
   );

   obs_t         q_a[$];
   obs_t         q_b[$];
   int           m_cnt[2][3];
   logic [2:0]   m_mask[2];
   logic [W-1:0] hold[2];
   int           n_checks = 0;
   int           n_errors = 0;

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d at %0t: actual=%0h required=%0h", name, k, $time, act, exp);
      end
   endtask

   function automatic logic [1:0] mode_from(input logic [2:0] m);
      int n;
      n = 3 - $countones(m);
      if (n == 3) return 2'b00;
      if (n == 2) return 2'b01;
      return 2'b10;
   endfunction

   task automatic model_clear(input int k);
      for (int r = 0; r < 3; r++) m_cnt[k][r] = 0;
      m_mask[k] = 3'b000;
   endtask

   // Behavioural reference: vote among surviving replicas, then bookkeeping
   task automatic model_beat(input int k, input int th, input logic [W-1:0] r0,
                             input logic [W-1:0] r1, input logic [W-1:0] r2,
                             input bit cl, output obs_t e);
      logic [W-1:0] rep[3];
      int           surv[$];
      int           maxc;
      int           ones;
      logic [W-1:0] vote;
      logic [2:0]   ed;
      logic         uc;
      rep[0] = r0; rep[1] = r1; rep[2] = r2;
      maxc = (1 << CW) - 1;
      vote = '0; ed = 3'b000; uc = 1'b0;
      for (int r = 0; r < 3; r++) if (!m_mask[k][r]) surv.push_back(r);
      if (surv.size() == 3) begin
         for (int b = 0; b < W; b++) begin
            ones = int'(r0[b]) + int'(r1[b]) + int'(r2[b]);
            vote[b] = (ones >= 2);
         end
         for (int r = 0; r < 3; r++) ed[r] = (rep[r] != vote);
      end else if (surv.size() == 2) begin
         vote = rep[surv[0]];
         uc   = (rep[surv[0]] != rep[surv[1]]);
      end else begin
         vote = rep[surv[0]];
      end
      if (cl) model_clear(k);
      else begin
         for (int r = 0; r < 3; r++) begin
            if (ed[r]) begin
               if (m_cnt[k][r] < maxc) m_cnt[k][r]++;
               if (th != 0 && m_cnt[k][r] >= th) m_mask[k][r] = 1'b1;
            end
         end
         if (m_mask[k] == 3'b111) m_mask[k] = 3'b110;
      end
      e.ov = 1'b1; e.dout = vote; e.ef = |ed; e.ed = ed; e.uc = uc;
      e.mode = mode_from(m_mask[k]); e.fm = m_mask[k];
      e.c0 = CW'(m_cnt[k][0]); e.c1 = CW'(m_cnt[k][1]); e.c2 = CW'(m_cnt[k][2]);
   endtask

   task automatic beat(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input bit cl, input bit rs);
      obs_t e;
      logic [W-1:0] r0, r1, r2;
      @(posedge aclk);
      #1;
      in_valid = v; d0 = a; d1 = b; d2 = c; clr = cl; areset = rs;
      r0 = a; r1 = b; r2 = c;
`ifdef TMR_VOTER_ERR_INJ_EN
      if (inj_en) begin
         if (inj_sel == 2'd0) r0 = r0 ^ inj_mask;
         if (inj_sel == 2'd1) r1 = r1 ^ inj_mask;
         if (inj_sel == 2'd2) r2 = r2 ^ inj_mask;
      end
`endif
      if (rs) begin
         model_clear(0);
         model_clear(1);
      end else if (v) begin
         model_beat(0, TH_A, r0, r1, r2, cl, e);
         q_a.push_back(e);
         model_beat(1, TH_B, r0, r1, r2, cl, e);
         q_b.push_back(e);
      end else if (cl) begin
         model_clear(0);
         model_clear(1);
      end
   endtask

   task automatic check_obs(input int k, input obs_t o, input bit rs);
      obs_t e;
      bit   empty;
      if (rs) begin
         chk("rst_out_valid", k, o.ov, 0);
         chk("rst_d_out", k, o.dout, 0);
         chk("rst_flags", k, {o.ef, o.ed, o.uc}, 0);
         chk("rst_mode", k, o.mode, 0);
         chk("rst_fail_mask", k, o.fm, 0);
         chk("rst_counts", k, {o.c0, o.c1, o.c2}, 0);
         hold[k] = '0;
      end else if (o.ov) begin
         empty = (k == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
         if (empty) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat dut%0d at %0t: actual=out_valid required=no beat",
                     k, $time);
         end else begin
            if (k == 0) e = q_a.pop_front();
            else        e = q_b.pop_front();
            chk("d_out", k, o.dout, e.dout);
            chk("err_flag", k, o.ef, e.ef);
            chk("err_d", k, o.ed, e.ed);
            chk("uncorr", k, o.uc, e.uc);
            chk("mode", k, o.mode, e.mode);
            chk("fail_mask", k, o.fm, e.fm);
            chk("err_cnt0", k, o.c0, e.c0);
            chk("err_cnt1", k, o.c1, e.c1);
            chk("err_cnt2", k, o.c2, e.c2);
            hold[k] = e.dout;
         end
      end else begin
         chk("idle_d_out_hold", k, o.dout, hold[k]);
         chk("idle_flags", k, {o.ef, o.ed, o.uc}, 0);
      end
   endtask

   initial begin
      bit rs;
      forever begin
         @(posedge aclk);
         rs = areset;
         @(negedge aclk);
         check_obs(0, obs_a, rs);
         check_obs(1, obs_b, rs);
      end
   end

   initial begin
      #2000000;
      n_errors++;
      $display("FAIL watchdog at %0t: actual=timeout required=finish", $time);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      logic [W-1:0] base, x0, x1, x2;
      hold[0] = '0; hold[1] = '0;
      model_clear(0); model_clear(1);
      repeat (3) beat(0, 8'h00, 8'h00, 8'h00, 0, 1);

      beat(1, 8'h5A, 8'h5A, 8'h5A, 0, 0);
      beat(1, 8'h5A, 8'h5A, 8'hA5, 0, 0);
      beat(1, 8'h01, 8'h02, 8'h03, 0, 0);
      beat(0, 8'h00, 8'h00, 8'h00, 0, 1);

      repeat (3) beat(1, 8'h33, 8'h33, 8'h3C, 0, 0);
      beat(1, 8'h11, 8'h22, 8'h11, 0, 0);
      beat(1, 8'h44, 8'h44, 8'h99, 0, 0);
      repeat (2) beat(0, 8'hFF, 8'hFF, 8'hFF, 0, 0);

      beat(0, 8'h00, 8'h00, 8'h00, 1, 0);
      repeat (3) beat(1, 8'hF0, 8'hF1, 8'hF2, 0, 0);
      beat(1, 8'hAA, 8'h00, 8'hFF, 0, 0);
      beat(1, 8'h3C, 8'hC3, 8'h77, 0, 0);

      beat(0, 8'h00, 8'h00, 8'h00, 0, 1);
      repeat (18) beat(1, 8'h80, 8'h00, 8'h00, 0, 0);
      beat(1, 8'h80, 8'h00, 8'h00, 1, 0);
      beat(1, 8'h80, 8'h00, 8'h00, 0, 0);
      beat(1, 8'h12, 8'h34, 8'h56, 0, 0);
      beat(1, 8'h12, 8'h34, 8'h56, 0, 1);
      beat(1, 8'h12, 8'h12, 8'h12, 0, 0);

`ifdef TMR_VOTER_ERR_INJ_EN
      beat(0, 8'h00, 8'h00, 8'h00, 0, 1);
      inj_en = 1'b1; inj_sel = 2'd1; inj_mask = 8'h01;
      beat(1, 8'h00, 8'h00, 8'h00, 0, 0);
      beat(0, 8'h00, 8'h00, 8'h00, 0, 0);
      inj_sel = 2'd3;
      beat(1, 8'h00, 8'h00, 8'h00, 0, 0);
      beat(0, 8'h00, 8'h00, 8'h00, 0, 0);
      inj_en = 1'b0;
`endif

      for (int i = 0; i < 1500; i++) begin
         base = W'($urandom);
         x0 = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
         x1 = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
         x2 = ($urandom_range(0, 4) == 0) ? W'($urandom) : '0;
         beat($urandom_range(0, 99) < 85, base ^ x0, base ^ x1, base ^ x2,
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
      end

      repeat (3) beat(0, 8'h00, 8'h00, 8'h00, 0, 0);
      chk("pending_beats", 0, q_a.size(), 0);
      chk("pending_beats", 1, q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
